// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between the L1 icache and
// the L1 dcache. A round-robin winner is latched in IDLE, its command is held
// on the memory port through BUSY, and a one-cycle response plus the returned
// line go back to that requester only in RESP. Saturating per-requester grant
// counters are kept for performance analysis.
//
// Handshake: a requester raises its request and holds request/address (and
// write data) stable until it sees its *_pmem_resp pulse, then drops the
// request in the following cycle. The memory holds mem_resp high for one
// cycle when the command completes; the command stays asserted until then.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic                  i_pmem_resp,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic                  d_pmem_resp,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  i_grant_count,
    output logic [CNT_WIDTH-1:0]  d_grant_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                  state_q, state_d;
    logic                    last_d_q;      // 1: dcache had the most recent grant
    logic                    owner_is_d_q;  // 1: dcache owns the current access
    logic                    write_q;       // latched op: 1 = write
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic [LINE_WIDTH-1:0]   i_rdata_q;
    logic [LINE_WIDTH-1:0]   d_rdata_q;
    logic [CNT_WIDTH-1:0]    i_cnt_q;
    logic [CNT_WIDTH-1:0]    d_cnt_q;

    logic i_req, d_req, any_req, win_dcache;

    // Round-robin choice between the two requesters while idle
    always_comb begin
        i_req      = i_pmem_read;
        d_req      = d_pmem_read | d_pmem_write;
        any_req    = i_req | d_req;
        win_dcache = d_req & (~i_req | ~last_d_q);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: grant on any request, wait for memory, one response cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req)  state_d = S_BUSY;
            S_BUSY:  if (mem_resp) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state and latched command
    always_comb begin
        mem_read    = (state_q == S_BUSY) & ~write_q;
        mem_write   = (state_q == S_BUSY) &  write_q;
        i_pmem_resp = (state_q == S_RESP) & ~owner_is_d_q;
        d_pmem_resp = (state_q == S_RESP) &  owner_is_d_q;
    end

    // Command latch, grant bookkeeping and read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d_q     <= 1'b1;
            owner_is_d_q <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_cnt_q      <= '0;
            d_cnt_q      <= '0;
        end else begin
            if (state_q == S_IDLE && any_req) begin
                owner_is_d_q <= win_dcache;
                last_d_q     <= win_dcache;
                // read+write together from the dcache is treated as a write
                write_q      <= win_dcache & d_pmem_write;
                addr_q       <= win_dcache ? d_pmem_address : i_pmem_address;
                if (win_dcache && d_pmem_write) wdata_q <= d_pmem_wdata;
                if (win_dcache) begin
                    if (d_cnt_q != '1) d_cnt_q <= d_cnt_q + CNT_ONE;
                end else begin
                    if (i_cnt_q != '1) i_cnt_q <= i_cnt_q + CNT_ONE;
                end
            end
            if (state_q == S_BUSY && mem_resp && !write_q) begin
                if (owner_is_d_q) d_rdata_q <= mem_rdata;
                else              i_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_address   = addr_q;
    assign mem_wdata     = wdata_q;
    assign i_pmem_rdata  = i_rdata_q;
    assign d_pmem_rdata  = d_rdata_q;
    assign i_grant_count = i_cnt_q;
    assign d_grant_count = d_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a task-driven memory responder, a scoreboard of
// expected read lines, and one task per scenario. A second instance with
// 2-bit counters shares all inputs to exercise counter saturation.
module tb_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
  localparam int CW = 16;

  logic          clk, reset_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_resp;
  logic [LW-1:0] i_pmem_rdata;
  logic          d_pmem_read, d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic          d_pmem_resp;
  logic [LW-1:0] d_pmem_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp;
  logic [LW-1:0] mem_rdata;
  logic [CW-1:0] i_grant_count, d_grant_count;
  logic [1:0]    dbg_state;

  // second instance outputs
  logic          s_i_resp, s_d_resp, s_mem_read, s_mem_write;
  logic [LW-1:0] s_i_rdata, s_d_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_address;
  logic [1:0]    s_i_cnt, s_d_cnt, s_state;

  logic [LW-1:0] exp_q[$];
  bit            exp_own_q[$];   // 1 = dcache
  int            tests_run, tests_failed;
  int            exp_icnt, exp_dcnt;
  logic [LW-1:0] last_d_line;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count),
    .dbg_state(dbg_state)
  );

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(s_i_resp), .i_pmem_rdata(s_i_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(s_d_resp), .d_pmem_rdata(s_d_rdata),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_address(s_mem_address),
    .mem_wdata(s_mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .i_grant_count(s_i_cnt), .d_grant_count(s_d_cnt),
    .dbg_state(s_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset_n = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_icnt = 0; exp_dcnt = 0;
  endtask

  // Memory side: wait for a command, hold it for lat cycles, pulse mem_resp.
  // Returns just after the edge on which mem_resp was sampled.
  task automatic mem_serve(input int lat, input logic [LW-1:0] line, input bit drop_i,
                           output bit seen, output int wait_cyc, output logic rd,
                           output logic wr, output logic [AW-1:0] addr,
                           output logic [LW-1:0] wd, output bit held);
    seen = 1'b0; wait_cyc = 0; held = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
    while (!seen && wait_cyc < 50) begin
      @(negedge clk);
      if (mem_read || mem_write) seen = 1'b1;
      else wait_cyc++;
    end
    if (!seen) return;
    rd = mem_read; wr = mem_write; addr = mem_address; wd = mem_wdata;
    if (drop_i) i_pmem_read = 1'b0;
    repeat (lat) begin
      @(negedge clk);
      if (mem_read !== rd || mem_write !== wr) held = 1'b0;
    end
    @(posedge clk);
    #1 mem_resp = 1'b1; mem_rdata = line;
    @(posedge clk);
    #1 mem_resp = 1'b0; mem_rdata = rand_line();
  endtask

  // Watch the response cycle and the IDLE cycle after it.
  // mode 0: drop the responder's request, 1: keep both, 2: drop both.
  task automatic wait_resp(input int mode, output int ni, output int nd, output bit first,
                           output logic [LW-1:0] ird, output logic [LW-1:0] drd);
    ni = 0; nd = 0; first = 1'b0; ird = '0; drd = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (i_pmem_resp) begin
        ni++; ird = i_pmem_rdata;
        if (k == 0) first = 1'b1;
        if (mode == 0) i_pmem_read = 1'b0;
      end
      if (d_pmem_resp) begin
        nd++; drd = d_pmem_rdata;
        if (k == 0) first = 1'b1;
        if (mode == 0) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      end
      if (mode == 2 && (i_pmem_resp || d_pmem_resp)) begin
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    #1;
    tests_run++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, i_pmem_resp, d_pmem_resp});
    end
    tests_run++;
    if (mem_address !== '0 || mem_wdata !== '0 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
      tests_failed++; $display("FAIL reset_data: addr %0h wdata %0h irdata %0h drdata %0h expected all 0", mem_address, mem_wdata, i_pmem_rdata, d_pmem_rdata);
    end
    tests_run++;
    if (i_grant_count !== '0 || d_grant_count !== '0 || dbg_state !== 2'd0) begin
      tests_failed++; $display("FAIL reset_cnt_state: icnt %0d dcnt %0d state %0d expected 0 0 0", i_grant_count, d_grant_count, dbg_state);
    end
    apply_reset();
    @(negedge clk);
    tests_run++;
    if (dbg_state !== 2'd0 || mem_read !== 1'b0) begin
      tests_failed++; $display("FAIL idle_no_req: state %0d mem_read %b expected 0 0", dbg_state, mem_read);
    end
  endtask

  task automatic test_icache_read();
    bit seen, held, first; int wc, ni, nd; logic rd, wr;
    logic [AW-1:0] addr; logic [LW-1:0] wd, ird, drd, line, exp_line;
    apply_reset();
    line = {16{8'hA5}};
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    exp_q.push_back(line); exp_own_q.push_back(1'b0); exp_icnt++;
    mem_serve(4, line, 1'b0, seen, wc, rd, wr, addr, wd, held);
    tests_run++;
    if (!seen || wc != 1) begin
      tests_failed++; $display("FAIL icache_cmd_latency: seen %b idle cycles %0d expected 1 1", seen, wc);
    end
    tests_run++;
    if ({rd, wr} !== 2'b10 || addr !== 16'h1230 || !held) begin
      tests_failed++; $display("FAIL icache_cmd: rd %b wr %b addr %0h held %b expected 1 0 1230 1", rd, wr, addr, held);
    end
    wait_resp(0, ni, nd, first, ird, drd);
    tests_run++;
    if (ni != 1 || nd != 0 || !first) begin
      tests_failed++; $display("FAIL icache_resp: i pulses %0d d pulses %0d first %b expected 1 0 1", ni, nd, first);
    end
    exp_line = exp_q.pop_front(); void'(exp_own_q.pop_front());
    tests_run++;
    if (ird !== exp_line) begin
      tests_failed++; $display("FAIL icache_rdata: got %h expected %h", ird, exp_line);
    end
    tests_run++;
    if (i_grant_count !== CW'(exp_icnt) || d_grant_count !== CW'(exp_dcnt)) begin
      tests_failed++; $display("FAIL icache_counts: got %0d %0d expected %0d %0d", i_grant_count, d_grant_count, exp_icnt, exp_dcnt);
    end
  endtask

  task automatic test_collisions();
    bit seen, held, first, own; int wc, ni, nd; logic rd, wr;
    logic [AW-1:0] addr; logic [LW-1:0] wd, ird, drd, line, exp_line;
    apply_reset();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0040;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0080;
    for (int g = 0; g < 4; g++) begin
      own = (g % 2 == 1);
      line = rand_line();
      exp_q.push_back(line); exp_own_q.push_back(own);
      if (own) exp_dcnt++; else exp_icnt++;
      mem_serve($urandom_range(0, 3), line, 1'b0, seen, wc, rd, wr, addr, wd, held);
      tests_run++;
      if (!seen || rd !== 1'b1 || addr !== (own ? 16'h0080 : 16'h0040)) begin
        tests_failed++; $display("FAIL collision%0d_cmd: seen %b rd %b addr %0h expected 1 1 %0h", g, seen, rd, addr, own ? 16'h0080 : 16'h0040);
      end
      wait_resp(g == 3 ? 2 : 1, ni, nd, first, ird, drd);
      exp_line = exp_q.pop_front(); own = exp_own_q.pop_front();
      tests_run++;
      if (ni != (own ? 0 : 1) || nd != (own ? 1 : 0)) begin
        tests_failed++; $display("FAIL collision%0d_owner: i pulses %0d d pulses %0d expected owner %s", g, ni, nd, own ? "D" : "I");
      end
      tests_run++;
      if ((own ? drd : ird) !== exp_line) begin
        tests_failed++; $display("FAIL collision%0d_rdata: got %h expected %h", g, own ? drd : ird, exp_line);
      end
      if (own) last_d_line = exp_line;
    end
    tests_run++;
    if (i_grant_count !== CW'(exp_icnt) || d_grant_count !== CW'(exp_dcnt)) begin
      tests_failed++; $display("FAIL collision_counts: got %0d %0d expected %0d %0d", i_grant_count, d_grant_count, exp_icnt, exp_dcnt);
    end
  endtask

  task automatic test_write_back();
    bit seen, held, first; int wc, ni, nd; logic rd, wr;
    logic [AW-1:0] addr; logic [LW-1:0] wd, ird, drd;
    logic [LW-1:0] wdata_a, wdata_b;
    wdata_a = 128'h0123456789ABCDEF0123456789ABCDEF;
    wdata_b = rand_line();
    // plain write, then the illegal read+write combination (acts as a write)
    for (int t = 0; t < 2; t++) begin
      d_pmem_write = 1'b1; d_pmem_read = (t == 1);
      d_pmem_address = (t == 0) ? 16'h2000 : 16'h2010;
      d_pmem_wdata = (t == 0) ? wdata_a : wdata_b;
      exp_dcnt++;
      mem_serve(2, rand_line(), 1'b0, seen, wc, rd, wr, addr, wd, held);
      tests_run++;
      if (!seen || {rd, wr} !== 2'b01 || !held) begin
        tests_failed++; $display("FAIL write%0d_cmd: seen %b rd %b wr %b held %b expected 1 0 1 1", t, seen, rd, wr, held);
      end
      tests_run++;
      if (addr !== ((t == 0) ? 16'h2000 : 16'h2010) || wd !== ((t == 0) ? wdata_a : wdata_b)) begin
        tests_failed++; $display("FAIL write%0d_data: addr %0h wdata %h expected %0h %h", t, addr, wd, (t == 0) ? 16'h2000 : 16'h2010, (t == 0) ? wdata_a : wdata_b);
      end
      wait_resp(0, ni, nd, first, ird, drd);
      tests_run++;
      if (nd != 1 || ni != 0 || drd !== last_d_line) begin
        tests_failed++; $display("FAIL write%0d_resp: d pulses %0d i pulses %0d drdata %h expected 1 0 %h", t, nd, ni, drd, last_d_line);
      end
    end
    tests_run++;
    if (d_grant_count !== CW'(exp_dcnt)) begin
      tests_failed++; $display("FAIL write_dcount: got %0d expected %0d", d_grant_count, exp_dcnt);
    end
  endtask

  task automatic test_drop_during_busy();
    bit seen, held, first; int wc, ni, nd; logic rd, wr;
    logic [AW-1:0] addr; logic [LW-1:0] wd, ird, drd, line, exp_line;
    line = rand_line();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0300;
    exp_q.push_back(line); exp_own_q.push_back(1'b0); exp_icnt++;
    mem_serve(6, line, 1'b1, seen, wc, rd, wr, addr, wd, held);
    tests_run++;
    if (!seen || rd !== 1'b1 || !held) begin
      tests_failed++; $display("FAIL drop_cmd_held: seen %b rd %b held %b expected 1 1 1", seen, rd, held);
    end
    wait_resp(0, ni, nd, first, ird, drd);
    exp_line = exp_q.pop_front(); void'(exp_own_q.pop_front());
    tests_run++;
    if (ni != 1 || nd != 0 || ird !== exp_line) begin
      tests_failed++; $display("FAIL drop_resp: i pulses %0d d pulses %0d rdata %h expected 1 0 %h", ni, nd, ird, exp_line);
    end
    @(negedge clk);
    tests_run++;
    if (dbg_state !== 2'd0 || mem_read !== 1'b0 || i_grant_count !== CW'(exp_icnt)) begin
      tests_failed++; $display("FAIL drop_idle: state %0d mem_read %b icnt %0d expected 0 0 %0d", dbg_state, mem_read, i_grant_count, exp_icnt);
    end
  endtask

  task automatic test_reset_in_busy();
    bit seen, held, first; int wc, ni, nd; logic rd, wr;
    logic [AW-1:0] addr; logic [LW-1:0] wd, ird, drd, line, exp_line;
    bit got_cmd;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0444;
    got_cmd = 1'b0;
    for (int k = 0; k < 20 && !got_cmd; k++) begin
      @(negedge clk);
      if (mem_read) got_cmd = 1'b1;
    end
    tests_run++;
    if (!got_cmd) begin
      tests_failed++; $display("FAIL rst_busy_cmd: mem_read not seen within 20 cycles");
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || mem_address !== '0 || dbg_state !== 2'd0) begin
      tests_failed++; $display("FAIL rst_busy_outputs: strobes %b addr %0h state %0d expected 0000 0 0", {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, mem_address, dbg_state);
    end
    tests_run++;
    if (d_pmem_rdata !== '0 || d_grant_count !== '0 || i_grant_count !== '0) begin
      tests_failed++; $display("FAIL rst_busy_regs: drdata %h icnt %0d dcnt %0d expected 0 0 0", d_pmem_rdata, i_grant_count, d_grant_count);
    end
    d_pmem_read = 1'b0; mem_resp = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_icnt = 0; exp_dcnt = 0;
    line = rand_line();
    d_pmem_read = 1'b1; d_pmem_address = 16'h0500;
    exp_q.push_back(line); exp_own_q.push_back(1'b1); exp_dcnt++;
    mem_serve(3, line, 1'b0, seen, wc, rd, wr, addr, wd, held);
    tests_run++;
    if (!seen || wc != 1 || addr !== 16'h0500 || rd !== 1'b1) begin
      tests_failed++; $display("FAIL rst_fresh_cmd: seen %b wait %0d addr %0h rd %b expected 1 1 500 1", seen, wc, addr, rd);
    end
    wait_resp(0, ni, nd, first, ird, drd);
    exp_line = exp_q.pop_front(); void'(exp_own_q.pop_front());
    tests_run++;
    if (nd != 1 || ni != 0 || drd !== exp_line || d_grant_count !== CW'(exp_dcnt)) begin
      tests_failed++; $display("FAIL rst_fresh_resp: d pulses %0d rdata %h dcnt %0d expected 1 %h %0d", nd, drd, d_grant_count, exp_line, exp_dcnt);
    end
  endtask

  task automatic test_saturation();
    bit seen, held, first; int wc, ni, nd; logic rd, wr;
    logic [AW-1:0] addr; logic [LW-1:0] wd, ird, drd, line, exp_line;
    logic [1:0] exp_sat;
    apply_reset();
    for (int g = 0; g < 5; g++) begin
      line = rand_line();
      i_pmem_read = 1'b1; i_pmem_address = AW'(16'h0100 + g * 16);
      exp_q.push_back(line); exp_own_q.push_back(1'b0); exp_icnt++;
      exp_sat = (exp_icnt > 3) ? 2'd3 : 2'(exp_icnt);
      mem_serve(1, line, 1'b0, seen, wc, rd, wr, addr, wd, held);
      tests_run++;
      if (!seen || s_i_cnt !== exp_sat || i_grant_count !== CW'(exp_icnt)) begin
        tests_failed++; $display("FAIL sat_grant%0d: seen %b cnt2 %0d cnt16 %0d expected 1 %0d %0d", g, seen, s_i_cnt, i_grant_count, exp_sat, exp_icnt);
      end
      wait_resp(0, ni, nd, first, ird, drd);
      exp_line = exp_q.pop_front(); void'(exp_own_q.pop_front());
      tests_run++;
      if (ni != 1 || ird !== exp_line) begin
        tests_failed++; $display("FAIL sat_resp%0d: i pulses %0d rdata %h expected 1 %h", g, ni, ird, exp_line);
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    exp_icnt = 0; exp_dcnt = 0; last_d_line = '0;
    test_reset();
    test_icache_read();
    test_collisions();
    test_write_back();
    test_drop_during_busy();
    test_reset_in_busy();
    test_saturation();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_empty: %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
